// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// Decodes a raw instruction plus format select into an XLEN immediate, one
// cycle after acceptance, behind a valid/ready handshake with an optional
// skid entry so backpressure does not cost throughput.
// Optional feature macro: RVC_IMM_EN (adds the rvc port and compressed formats).
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   flush                drop held entries; refuse the offered entry this cycle
//   in_valid, in_ready   input handshake (instr, immsrc[, rvc])
//   instr, immsrc        raw instruction and immediate format select
//   rvc                  compressed-format select (RVC_IMM_EN only)
//   out_valid, out_ready output handshake (immext, illegal)
//   immext, illegal      extended immediate and reserved-format flag
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
`ifdef RVC_IMM_EN
  input  logic            rvc,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  logic [63:0]     imm64_c;
  logic [XLEN-1:0] imm_c;
  logic            ill_c;
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_ill;
  logic            accept;
  logic            drain;
  logic            unused_bits;

  // Decode at 64 bits and truncate, so one table serves both XLEN values.
  always_comb begin
    imm64_c = '0;
    ill_c   = 1'b0;
`ifdef RVC_IMM_EN
    if (rvc) begin
      case (immsrc)
        3'b000: imm64_c = {{58{instr[12]}}, instr[12], instr[6:2]};
        3'b001: imm64_c = {{52{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                           instr[7], instr[2], instr[11], instr[5:3], 1'b0};
        3'b010: imm64_c = {{55{instr[12]}}, instr[12], instr[6:5], instr[2],
                           instr[11:10], instr[4:3], 1'b0};
        3'b011: imm64_c = {54'b0, instr[10:7], instr[12:11], instr[5], instr[6], 2'b00};
        3'b100: imm64_c = {57'b0, instr[5], instr[12:10], instr[6], 2'b00};
        3'b101: imm64_c = {{46{instr[12]}}, instr[12], instr[6:2], 12'b0};
        default: ill_c  = 1'b1;
      endcase
    end else
`endif
    begin
      case (immsrc)
        3'b000: imm64_c = {{52{instr[31]}}, instr[31:20]};
        3'b001: imm64_c = {{52{instr[31]}}, instr[31:25], instr[11:7]};
        3'b010: imm64_c = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        3'b011: imm64_c = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        3'b100: imm64_c = {{32{instr[31]}}, instr[31:12], 12'b0};
        3'b101: imm64_c = {59'b0, instr[19:15]};
        3'b110: imm64_c = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
        default: ill_c  = 1'b1;
      endcase
    end
  end

  assign imm_c = imm64_c[XLEN-1:0];

  // Opcode bits and the truncated upper half are legitimately unused in some builds.
  assign unused_bits = ^{instr[6:0], imm64_c[63:32]};

  // Ready depends on held state only (plus flush refusal) when the skid is present.
  assign in_ready = (SKID_EN ? !skid_valid : (!out_valid || out_ready)) && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Main/skid buffer: main refills from skid first to keep FIFO order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      immext     <= '0;
      illegal    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        immext     <= skid_imm;
        illegal    <= skid_ill;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        immext    <= imm_c;
        illegal   <= ill_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_imm   <= imm_c;
      skid_ill   <= ill_c;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed spec scenarios followed by random
// traffic, checked against a queue-based reference of held entries. Two DUTs
// (XLEN=32 and XLEN=64) share the same stimulus.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, rvc;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic        ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   chk_zero = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .immsrc(immsrc),
`ifdef RVC_IMM_EN
    .rvc(rvc),
`endif
    .out_valid(ov32), .out_ready(out_ready), .immext(imm32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .immsrc(immsrc),
`ifdef RVC_IMM_EN
    .rvc(rvc),
`endif
    .out_valid(ov64), .out_ready(out_ready), .immext(imm64), .illegal(ill64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the format definitions, as signed/unsigned arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [2:0] s, input logic c);
    exp_t   e;
    longint v;
    v     = 0;
    e.ill = 1'b0;
    e.imm32 = '0;
`ifdef RVC_IMM_EN
    if (c) begin
      case (s)
        3'd0: v = longint'($signed({i[12], i[6:2]}));
        3'd1: v = longint'($signed({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3]})) * 2;
        3'd2: v = longint'($signed({i[12], i[6:5], i[2], i[11:10], i[4:3]})) * 2;
        3'd3: v = longint'({i[10:7], i[12:11], i[5], i[6]}) * 4;
        3'd4: v = longint'({i[5], i[12:10], i[6]}) * 4;
        3'd5: v = longint'($signed({i[12], i[6:2]})) * 4096;
        default: e.ill = 1'b1;
      endcase
      e.imm64 = v;
      e.imm32 = e.imm64[31:0];
      return e;
    end
`else
    if (c) e.ill = 1'b0;
`endif
    case (s)
      3'd0: v = longint'($signed(i[31:20]));
      3'd1: v = longint'($signed({i[31:25], i[11:7]}));
      3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      3'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      3'd4: v = longint'($signed(i[31:12])) * 4096;
      3'd5: v = longint'(i[19:15]);
      3'd6: v = longint'(i[25:20]);
      default: e.ill = 1'b1;
    endcase
    e.imm64 = v;
    e.imm32 = (s == 3'd6) ? 32'(i[24:20]) : e.imm64[31:0];
    return e;
  endfunction

  // One clock: drive, check held state against the model, advance model.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [2:0] src,
                      input bit c, input bit rdy, input bit fl, input bit rst);
    bit exp_ready, acc, dlv;
    in_valid = iv; instr = ins; immsrc = src; rvc = c;
    out_ready = rdy; flush = fl; reset = rst;
    #1;
    exp_ready = !fl && (q.size() < 2);
    check_eq("in_ready32", 64'(ir32), 64'(exp_ready));
    check_eq("in_ready64", 64'(ir64), 64'(exp_ready));
    check_eq("out_valid32", 64'(ov32), 64'(q.size() != 0));
    check_eq("out_valid64", 64'(ov64), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("immext32", 64'(imm32), 64'(q[0].imm32));
      check_eq("immext64", imm64, q[0].imm64);
      check_eq("illegal32", 64'(ill32), 64'(q[0].ill));
      check_eq("illegal64", 64'(ill64), 64'(q[0].ill));
    end else if (chk_zero) begin
      check_eq("zero_imm32", 64'(imm32), 64'd0);
      check_eq("zero_imm64", imm64, 64'd0);
      check_eq("zero_ill", 64'(ill32 | ill64), 64'd0);
    end
    acc = iv && exp_ready;
    dlv = (q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      chk_zero = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(ins, src, c));
      if (dlv || acc) chk_zero = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rvc = 1'b0; instr = '0; immsrc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("reset_in_ready", 64'(ir32), 64'd1);
    check_eq("reset_out_valid", 64'(ov32 | ov64), 64'd0);
    check_eq("reset_immext", 64'(imm32), 64'd0);

    // I-type all-ones immediate
    step(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("I_valid", 64'(ov32), 64'd1);
    check_eq("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
    check_eq("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    // B then U back-to-back
    step(1'b1, 32'hFE000EE3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("B_imm32", 64'(imm32), 64'hFFFF_FFFC);
    step(1'b1, 32'h123452B7, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("U_imm32", 64'(imm32), 64'h1234_5000);
    check_eq("U_valid", 64'(ov32), 64'd1);
    // Z, SH, reserved
    step(1'b1, 32'h000F8000, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("Z_imm32", 64'(imm32), 64'h1F);
    step(1'b1, 32'h03F00000, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("SH_imm64", imm64, 64'h3F);
    check_eq("SH_imm32", 64'(imm32), 64'h1F);
    step(1'b1, 32'hFFFFFFFF, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("RSV_imm", 64'(imm32), 64'd0);
    check_eq("RSV_ill", 64'(ill32), 64'd1);
    idle(2);

    // Backpressure: three offers while stalled, only two fit
    step(1'b1, 32'h00100013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("BP_in_ready", 64'(ir32), 64'd0);
    check_eq("BP_head", 64'(imm32), 64'd1);
    step(1'b1, 32'h00300013, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("BP_second", 64'(imm32), 64'd2);
    step(1'b1, 32'h00300013, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("BP_third", 64'(imm32), 64'd3);
    idle(2);

    // Flush with both entries held and a new offer
    step(1'b1, 32'h00400013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00500013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00600013, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("FL_out_valid", 64'(ov32), 64'd0);
    idle(3);

    // Reset mid-stream
    step(1'b1, 32'hFFF00013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFE00013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("RST_imm32", 64'(imm32), 64'd0);
    check_eq("RST_valid", 64'(ov32), 64'd0);
    idle(2);

`ifdef RVC_IMM_EN
    step(1'b1, 32'h000050FD, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("CI_imm32", 64'(imm32), 64'hFFFF_FFFF);
`else
    step(1'b1, 32'h000050FD, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("noRVC_I", 64'(imm32), 64'd0);
`endif
    idle(2);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit c;
`ifdef RVC_IMM_EN
      c = 1'($urandom_range(0, 1));
`else
      c = 1'b0;
`endif
      step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), c,
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) < 1);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
